// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//
// Instruction fetch front end. Holds the fetch PC and issues word-addressed
// read requests to instruction memory. Returned words are buffered with
// their PCs in a DEPTH-entry FIFO and handed downstream as {inst, pc}.
// A redirect flushes the FIFO and restarts fetch at a new PC. Halt stops new
// requests, but requests already in flight still complete.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   mem_req_valid   request to instruction memory (combinational)
//   mem_req_addr    word address of the request, fetch_pc[31:2] (combinational)
//   mem_req_ready   memory accepts the request this cycle
//   mem_resp_valid  response word valid; responses return in request order
//   mem_resp_data   instruction word
//   inst_valid      FIFO head valid
//   inst, inst_pc   FIFO head instruction and its PC (0 when empty)
//   inst_ready      downstream consumes the head
//   redirect        flush and restart at redirect_pc
//   redirect_pc     new fetch PC; bits [1:0] ignored
//   halt            suppress new requests
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [29:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so that count + inflight cannot overflow in the credit check.
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] inflight_reg, inflight_next;
  logic [CNT_W-1:0] discard_reg, discard_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           accept;
  logic           discarding;
  logic           push;
  logic           pop;
  logic [31:0]    redirect_pc_aligned;
  logic           unused_redirect_bits;

  assign redirect_pc_aligned  = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Credit rule: a request is only issued while every accepted-but-unreturned
  // request is guaranteed a FIFO slot, so responses never need backpressure.
  assign occupancy     = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign mem_req_valid = reset && !halt && !redirect && (occupancy < DEPTH_W);
  assign mem_req_addr  = fetch_pc_reg[31:2];

  assign accept     = mem_req_valid && mem_req_ready;
  assign discarding = (discard_reg != '0);
  // A response landing in a redirect cycle belongs to the old stream.
  assign push       = mem_resp_valid && !redirect && !discarding;

  assign inst_valid = (count_reg != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? inst_mem[head_reg] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[head_reg]   : 32'h0;

  always_comb begin
    inflight_next = inflight_reg;
    if (accept && !mem_resp_valid) begin
      inflight_next = inflight_reg + 1'b1;
    end else if (!accept && mem_resp_valid) begin
      inflight_next = inflight_reg - 1'b1;
    end
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    count_next    = count_reg;
    discard_next  = discard_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    if (redirect) begin
      fetch_pc_next = redirect_pc_aligned;
      resp_pc_next  = redirect_pc_aligned;
      count_next    = '0;
      head_next     = '0;
      tail_next     = '0;
      // Everything still outstanding after this cycle's return is stale.
      discard_next  = inflight_next;
    end else begin
      if (accept) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (mem_resp_valid && discarding) begin
        discard_next = discard_reg - 1'b1;
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        tail_next    = tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_next = head_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      count_reg    <= '0;
      inflight_reg <= '0;
      discard_reg  <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      discard_reg  <= discard_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  // Entry storage needs no reset: the outputs are gated by count.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[tail_reg] <= mem_resp_data;
      pc_mem[tail_reg]   <= resp_pc_reg;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps
module tb_inst_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic [29:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;

  // Second instance exercising PC wrap-around.
  logic        req_valid_b;
  logic [29:0] req_addr_b;
  logic        resp_valid_b = 1'b0;
  logic [31:0] resp_data_b = 32'h0;
  logic        inst_valid_b;
  logic [31:0] inst_b;
  logic [31:0] inst_pc_b;

  int tests  = 0;
  int failed = 0;
  int lat    = 1;
  int accept_cnt = 0;
  int edge_cnt   = 0;

  inst_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  inst_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clock(clock), .reset(reset),
    .mem_req_valid(req_valid_b), .mem_req_addr(req_addr_b),
    .mem_req_ready(1'b1),
    .mem_resp_valid(resp_valid_b), .mem_resp_data(resp_data_b),
    .inst_valid(inst_valid_b), .inst(inst_b), .inst_pc(inst_pc_b),
    .inst_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0)
  );

  always #10 clock = ~clock;

  always @(posedge clock) edge_cnt++;

  // Memory model for the main instance: fixed latency 'lat', in order,
  // word = addr*4+1. Decides its inputs just before each rising edge.
  typedef struct { logic [29:0] addr; int due; } req_t;
  req_t pend[$];

  always @(negedge clock) begin
    #8;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    if (!reset) begin
      pend.delete();
      accept_cnt = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == edge_cnt + 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = {pend[0].addr, 2'b00} + 32'd1;
        void'(pend.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{mem_req_addr, edge_cnt + 1 + lat});
        accept_cnt++;
      end
    end
  end

  // Single-cycle memory for the wrap instance.
  logic        pend_b = 1'b0;
  logic [29:0] pend_addr_b = 30'h0;
  always @(negedge clock) begin
    #8;
    if (!reset) begin
      pend_b       = 1'b0;
      resp_valid_b = 1'b0;
      resp_data_b  = 32'h0;
    end else begin
      resp_valid_b = pend_b;
      resp_data_b  = {pend_addr_b, 2'b00} + 32'd1;
      pend_b       = req_valid_b;
      pend_addr_b  = req_addr_b;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  // Returns 3 time units after a falling edge; stimulus set here is seen by
  // the memory model and the DUT before the next rising edge.
  task automatic nxt();
    @(negedge clock);
    #3;
  endtask

  task automatic do_reset(input int latency, input logic ready);
    reset = 1'b0;
    nxt();
    nxt();
    lat        = latency;
    inst_ready = ready;
    halt       = 1'b0;
    redirect   = 1'b0;
    reset      = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    nxt();
    // Reset state
    check_val("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check_val("rst_req_addr", {2'b00, mem_req_addr}, 32'h0);
    check_val("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check_val("rst_inst", inst, 32'h0);
    check_val("rst_inst_pc", inst_pc, 32'h0);
    check_val("rst_wrap_addr", {2'b00, req_addr_b}, 32'h3FFF_FFFE);

    // Streaming, 1-cycle memory, consumer always ready
    lat = 1; inst_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_val("first_req_valid", {31'h0, mem_req_valid}, 32'h1);
    nxt();
    check_val("one_edge_no_inst", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      nxt();
      check_val($sformatf("stream_valid_%0d", i), {31'h0, inst_valid}, 32'h1);
      check_val($sformatf("stream_pc_%0d", i), inst_pc, 32'(4 * i));
      check_val($sformatf("stream_inst_%0d", i), inst, 32'(4 * i + 1));
      check_val($sformatf("wrap_pc_%0d", i), inst_pc_b, 32'hFFFF_FFF8 + 32'(4 * i));
      check_val($sformatf("wrap_inst_%0d", i), inst_b, 32'hFFFF_FFF9 + 32'(4 * i));
    end

    // Backpressure: FIFO fills to DEPTH, requests stop, then drain resumes
    do_reset(1, 1'b0);
    repeat (8) nxt();
    check_val("full_accepts", 32'(accept_cnt), 32'd4);
    check_val("full_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check_val("full_inst_valid", {31'h0, inst_valid}, 32'h1);
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("drain_pc_%0d", i), inst_pc, 32'(4 * i));
      nxt();
    end

    // Redirect with 3 requests in flight on a 3-cycle memory
    do_reset(3, 1'b1);
    nxt(); nxt(); nxt();
    check_val("redir_inflight", 32'(accept_cnt), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check_val("redir_no_req", {31'h0, mem_req_valid}, 32'h0);
    nxt();
    redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    check_val("redir_new_addr", {2'b00, mem_req_addr}, 32'h40);
    check_val("redir_new_valid", {31'h0, mem_req_valid}, 32'h1);
    check_val("redir_flushed", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 12 && !inst_valid; i++) nxt();
    check_val("redir_seen", {31'h0, inst_valid}, 32'h1);
    check_val("redir_first_pc", inst_pc, 32'h100);
    check_val("redir_first_inst", inst, 32'h101);
    nxt();
    check_val("redir_second_pc", inst_pc, 32'h104);

    // Halt with 2 in flight
    do_reset(3, 1'b1);
    nxt(); nxt();
    halt = 1'b1;
    #1;
    check_val("halt_no_req", {31'h0, mem_req_valid}, 32'h0);
    nxt();
    nxt();
    check_val("halt_head0_valid", {31'h0, inst_valid}, 32'h1);
    check_val("halt_head0_pc", inst_pc, 32'h0);
    nxt();
    check_val("halt_head1_pc", inst_pc, 32'h4);
    nxt();
    check_val("halt_drained", {31'h0, inst_valid}, 32'h0);
    check_val("halt_accepts", 32'(accept_cnt), 32'd2);
    halt = 1'b0;
    #1;
    check_val("unhalt_valid", {31'h0, mem_req_valid}, 32'h1);
    check_val("unhalt_addr", {2'b00, mem_req_addr}, 32'h2);

    // Asynchronous reset with the FIFO half full
    do_reset(1, 1'b0);
    nxt(); nxt(); nxt();
    check_val("half_valid", {31'h0, inst_valid}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check_val("async_inst_valid", {31'h0, inst_valid}, 32'h0);
    check_val("async_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check_val("async_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    nxt();
    reset = 1'b1;
    #1;
    check_val("restart_addr", {2'b00, mem_req_addr}, 32'h0);
    nxt();
    nxt();
    check_val("restart_valid", {31'h0, inst_valid}, 32'h1);
    check_val("restart_pc", inst_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
